// File: rtl/injector_pkg.sv
// Shared constants and types for the host_injector ingress path.
package injector_pkg;

    localparam int DW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 16;
    localparam int NUM_LANES     = 3;

    localparam logic [2:0] ADDR_LANE0  = 3'd0;
    localparam logic [2:0] ADDR_LANE1  = 3'd1;
    localparam logic [2:0] ADDR_LANE2  = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_DROP0  = 3'd4;
    localparam logic [2:0] ADDR_DROP1  = 3'd5;
    localparam logic [2:0] ADDR_DROP2  = 3'd6;
    localparam logic [2:0] ADDR_CTRL   = 3'd7;

    typedef logic [1:0] lane_idx_t;

    // Status byte layout: {2'b0, overflow[2:0], full[2:0]}
    localparam int STAT_FULL_LSB = 0;
    localparam int STAT_OVF_LSB  = 3;

    localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/lane_fifo.sv
// Single-clock show-ahead FIFO feeding one switch input port.
module lane_fifo
    import injector_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          ready,
    input  logic          flush,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Handshake: a byte moves when valid (= !empty) and ready are both high at
    // a rising edge; while valid && !ready the head byte and valid hold.
    assign pop     = ready && !empty && !flush;
    assign push_ok = push && !full && !flush;
    // Full is judged on the pre-edge count, so a same-cycle pop cannot rescue a push.
    assign overflow = push && full && !flush;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/host_injector.sv
// Host-to-switch ingress: slave-port writes into three lane FIFOs plus status/drop registers.
// Optional lane flush via address 7 is built when INJECTOR_FLUSH_EN is defined.
module host_injector
    import injector_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          chipselect,
    input  logic          write,
    input  logic          read,
    input  logic [2:0]    address,
    input  logic [DW-1:0] writedata,
    output logic [DW-1:0] readdata,
    output logic [DW-1:0] out_data1,
    output logic [DW-1:0] out_data2,
    output logic [DW-1:0] out_data3,
    output logic          out_valid1,
    output logic          out_valid2,
    output logic          out_valid3,
    input  logic          out_ready1,
    input  logic          out_ready2,
    input  logic          out_ready3
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                 wr_en;
    logic                 rd_en;
    logic [NUM_LANES-1:0] lane_push;
    logic [NUM_LANES-1:0] lane_flush;
    logic [NUM_LANES-1:0] lane_ready;
    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] lane_empty;
    logic [NUM_LANES-1:0] lane_ovf_pulse;
    logic [NUM_LANES-1:0] ovf_flag;
    logic [DW-1:0]        lane_head  [NUM_LANES];
    logic [CW-1:0]        lane_count [NUM_LANES];
    logic [7:0]           drop_cnt   [NUM_LANES];
    logic [DW-1:0]        rd_mux;
    logic [DW-1:0]        capability;

    assign wr_en = chipselect && write;
    assign rd_en = chipselect && read;

    assign lane_ready = {out_ready3, out_ready2, out_ready1};

    always_comb begin
        lane_push = '0;
        if (wr_en) begin
            case (address)
                ADDR_LANE0: lane_push[0] = 1'b1;
                ADDR_LANE1: lane_push[1] = 1'b1;
                ADDR_LANE2: lane_push[2] = 1'b1;
                default:    lane_push = '0;
            endcase
        end
    end

`ifdef INJECTOR_FLUSH_EN
    assign lane_flush = (wr_en && address == ADDR_CTRL) ? writedata[NUM_LANES-1:0] : '0;
    assign capability = DW'(8'h01);
`else
    assign lane_flush = '0;
    assign capability = DW'(8'h00);
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (lane_push[g]),
            .push_data (writedata),
            .ready     (lane_ready[g]),
            .flush     (lane_flush[g]),
            .head_data (lane_head[g]),
            .full      (lane_full[g]),
            .empty     (lane_empty[g]),
            .count     (lane_count[g]),
            .overflow  (lane_ovf_pulse[g])
        );

        // Overflow is sticky until the host clears it; drop counts saturate.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ovf_flag[g] <= 1'b0;
                drop_cnt[g] <= '0;
            end else begin
                if (lane_ovf_pulse[g]) begin
                    ovf_flag[g] <= 1'b1;
                end else if (wr_en && address == ADDR_STATUS && writedata[g]) begin
                    ovf_flag[g] <= 1'b0;
                end
                if (lane_ovf_pulse[g] && drop_cnt[g] != DROP_MAX) begin
                    drop_cnt[g] <= drop_cnt[g] + 8'd1;
                end
            end
        end
    end

    assign out_data1  = lane_head[0];
    assign out_data2  = lane_head[1];
    assign out_data3  = lane_head[2];
    assign out_valid1 = !lane_empty[0];
    assign out_valid2 = !lane_empty[1];
    assign out_valid3 = !lane_empty[2];

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_LANE0:  rd_mux = DW'(lane_count[0]);
            ADDR_LANE1:  rd_mux = DW'(lane_count[1]);
            ADDR_LANE2:  rd_mux = DW'(lane_count[2]);
            ADDR_STATUS: begin
                rd_mux[STAT_FULL_LSB +: NUM_LANES] = lane_full;
                rd_mux[STAT_OVF_LSB  +: NUM_LANES] = ovf_flag;
            end
            ADDR_DROP0:  rd_mux = DW'(drop_cnt[0]);
            ADDR_DROP1:  rd_mux = DW'(drop_cnt[1]);
            ADDR_DROP2:  rd_mux = DW'(drop_cnt[2]);
            ADDR_CTRL:   rd_mux = capability;
            default:     rd_mux = '0;
        endcase
    end

    // Reads sample pre-edge state, so a same-cycle write is not yet visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end else begin
            readdata <= '0;
        end
    end

endmodule

// File: doc/host_injector.md
Name: host_injector

Overview:
- Host-to-switch ingress path; the write-direction counterpart of the switch-output read buffer.
- The host CPU writes bytes over an Avalon-MM-style slave port into three per-lane FIFOs.
- Each FIFO drains into one switch input port over a valid/ready handshake.
- Status, occupancy and drop counters are readable over the same slave port.

Parameters:
- DW, 8, data byte width (host bus and lane data)
- DEPTH, 16, entries per lane FIFO; power of two, minimum 2
- CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridable)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- chipselect  in  1  slave select
- write  in  1  slave write strobe, qualified by chipselect
- read  in  1  slave read strobe, qualified by chipselect
- address  in  3  register address
- writedata  in  DW  host write data
- readdata  out  DW  host read data, registered
- out_data1, out_data2, out_data3  out  DW  lane head byte
- out_valid1, out_valid2, out_valid3  out  1  lane has data
- out_ready1, out_ready2, out_ready3  in  1  switch port accepts byte

Behaviour:
- Reset (async assert, sync release): all FIFOs empty (pointers and counts 0); out_valid* = 0; overflow flags = 0; drop counters = 0; readdata = 0.
- out_data* is don't-care while its out_valid is 0.
- Write map (chipselect && write):
  - addr 0/1/2: push writedata into lane 1/2/3.
  - addr 3: clear overflow flags where writedata[2:0] = 1.
  - addr 7: see Optional Feature.
  - addr 4-6: ignored.
- Push to a full lane:
  - Byte is dropped and the FIFO is unchanged.
  - The lane's overflow flag is set (sticky).
  - The lane's drop counter increments, saturating at 255.
- Full is evaluated on the pre-cycle count: a push to a full lane is dropped even if a pop occurs in the same cycle.
- Pop: out_valid && out_ready in the same cycle. Removes the head byte; the next entry appears the following cycle.
- Show-ahead FIFO: out_valid = (count != 0); out_data = head entry, combinational from the registered memory and pointer.
- Latency: a byte written at edge N is valid after edge N; a consumer can take it at edge N+1.
- Handshake stability: while valid && !ready, data and valid hold; valid never drops without a pop or flush.
- Simultaneous push and pop on a non-full, non-empty lane: count unchanged, both take effect.
- Push to an empty lane with ready already high: byte is stored, no pop that cycle (valid was 0).
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Read map (chipselect && read), readdata registered, 1-cycle latency:
  - addr 0/1/2: lane occupancy, zero-extended.
  - addr 3: {2'b0, overflow[2:0], full[2:0]}.
  - addr 4/5/6: lane 1/2/3 drop counter.
  - addr 7: capability byte, 8'h01 with the flush feature, else 8'h00.
- When not reading, readdata <= 0.
- Write and read in the same cycle: both are honoured. A read of status or occupancy returns pre-write values.
- Reset asserted mid-transfer: all in-flight bytes are lost, out_valid* falls immediately (async).

Optional Feature:
- Macro: INJECTOR_FLUSH_EN.
- Defined:
  - A write to addr 7 empties every lane where writedata[2:0] = 1 (pointers and count to 0) at the next edge; out_valid falls after that edge.
  - A flush beats a same-cycle push or pop on that lane; the pushed byte is discarded without setting overflow.
  - Capability read returns 8'h01.
- Undefined: addr 7 writes are ignored; capability read returns 8'h00.

Decomposition:
- Package injector_pkg:
  - Address constants: ADDR_LANE0..2, ADDR_STATUS, ADDR_DROP0..2, ADDR_CTRL.
  - Default DW and DEPTH.
  - Lane index typedef.
  - Status bit-position constants.
- Sub-module lane_fifo:
  - Single-clock show-ahead FIFO with push, pop, flush, full, empty, count and overflow-pulse outputs.
  - Instantiated three times.
  - Top level holds address decode, overflow flags, drop counters and readdata.

Test Plan:
- Reset, then write 8'h11, 8'h22 to addr 0 with out_ready1 = 0 -> out_valid1 = 1, out_data1 = 8'h11 held for 3 cycles; read addr 0 returns 2.
- Raise out_ready1 for 2 cycles -> 8'h11 then 8'h22 consumed; out_valid1 = 0; occupancy 0.
- Write 18 bytes to addr 1 with out_ready2 = 0 -> occupancy 16; status reads 8'b00_010_010; drop counter at addr 5 reads 2; first and last stored bytes are byte 1 and byte 16.
- Write 8'h02 to addr 3 -> overflow bit clears (status 8'b00_000_010); drop counter stays 2.
- Lane 3 holding 4 bytes, push and pop in the same cycle -> occupancy stays 4; byte order preserved.
- With INJECTOR_FLUSH_EN, lane 1 holding 5 bytes, write 8'h01 to addr 7 -> out_valid1 = 0 next cycle; addr 7 reads 8'h01. Without the macro, the same write leaves occupancy at 5.
